// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the
// interpolator, scheduler and FIR bank.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;

  localparam logic CHAN_L = 1'b0;
  localparam logic CHAN_R = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/chan_pending_buf.sv
// One-deep pending sample buffer for a single channel,
// newest sample wins, with overrun event detect.
module chan_pending_buf #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  grant,
  input  logic                  run,
  input  logic                  clr,
  output logic                  pend,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ovr_evt
);

  logic accept;

  assign accept  = en & run;
  // a granted sample leaves this cycle, so a new one is no overrun
  assign ovr_evt = accept & pend & ~grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (accept) begin
      pend <= 1'b1;
      dout <= din;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR MAC engine
// between the left and right sample streams.
module fir_channel_scheduler
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH     = AUDIO_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 2047,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clr_status,
  input  logic                  l_data_en,
  input  logic                  r_data_en,
  input  logic [DATA_WIDTH-1:0] l_data_in,
  input  logic [DATA_WIDTH-1:0] r_data_in,
  output logic                  eng_start,
  output logic                  eng_chan,
  output logic [DATA_WIDTH-1:0] eng_data,
  input  logic                  eng_done,
  output logic                  busy,
  output logic                  l_overrun,
  output logic                  r_overrun,
  output logic                  timeout_err
);

  state_t state;
  state_t state_nxt;

  logic                  l_pend;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] l_dout;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  l_ovr;
  logic                  r_ovr;
  logic                  granting;
  logic                  sel_r;
  logic                  grant_l;
  logic                  grant_r;
  logic                  last_served;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  tmo_evt;

  chan_pending_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_l_buf (
    .clk    (clk),
    .reset  (reset),
    .en     (l_data_en),
    .din    (l_data_in),
    .grant  (grant_l),
    .run    (run),
    .clr    (~run),
    .pend   (l_pend),
    .dout   (l_dout),
    .ovr_evt(l_ovr)
  );

  chan_pending_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_r_buf (
    .clk    (clk),
    .reset  (reset),
    .en     (r_data_en),
    .din    (r_data_in),
    .grant  (grant_r),
    .run    (run),
    .clr    (~run),
    .pend   (r_pend),
    .dout   (r_dout),
    .ovr_evt(r_ovr)
  );

  // right wins only when alone or when left was served last
  assign granting = (state == IDLE) & run & (l_pend | r_pend);
  assign sel_r    = r_pend & (~l_pend | (last_served == CHAN_L));
  assign grant_l  = granting & ~sel_r;
  assign grant_r  = granting & sel_r;

  assign cnt_inc = cnt + CNT_W'(1);
  assign tmo_evt = (state == WAIT) & ~eng_done
                 & (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (granting) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done || tmo_evt) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    eng_start = (state == ISSUE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_chan    <= CHAN_L;
      eng_data    <= '0;
      last_served <= CHAN_R;
      cnt         <= '0;
    end else begin
      if (granting) begin
        eng_chan    <= sel_r;
        eng_data    <= sel_r ? r_dout : l_dout;
        last_served <= sel_r;
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT && !eng_done) begin
        cnt <= cnt_inc;
      end
    end
  end

  // set events take priority over a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_overrun   <= 1'b0;
      r_overrun   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      l_overrun   <= (l_overrun & ~clr_status) | l_ovr;
      r_overrun   <= (r_overrun & ~clr_status) | r_ovr;
      timeout_err <= (timeout_err & ~clr_status) | tmo_evt;
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler against a
// job-level reference model with randomized traffic.
module tb_fir_channel_scheduler;

  localparam int T  = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          clr_status = 1'b0;
  logic          l_data_en = 1'b0;
  logic          r_data_en = 1'b0;
  logic [DW-1:0] l_data_in = '0;
  logic [DW-1:0] r_data_in = '0;
  logic          eng_done = 1'b0;
  logic          eng_start;
  logic          eng_chan;
  logic [DW-1:0] eng_data;
  logic          busy;
  logic          l_overrun;
  logic          r_overrun;
  logic          timeout_err;

  fir_channel_scheduler #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .clr_status (clr_status),
    .l_data_en  (l_data_en),
    .r_data_en  (r_data_en),
    .l_data_in  (l_data_in),
    .r_data_in  (r_data_in),
    .eng_start  (eng_start),
    .eng_chan   (eng_chan),
    .eng_data   (eng_data),
    .eng_done   (eng_done),
    .busy       (busy),
    .l_overrun  (l_overrun),
    .r_overrun  (r_overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit start;
    bit busy;
    bit lo;
    bit ro;
    bit to;
  } stat_t;

  typedef struct {
    int            cyc;
    bit            chan;
    logic [DW-1:0] data;
  } job_t;

  stat_t sq[$];
  job_t  jq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  // reference model: engine phase 0=free, 1=start cycle, 2=running
  bit            m_pend[2];
  logic [DW-1:0] m_buf[2];
  bit            m_last;
  int            m_phase;
  int            m_waited;
  bit            m_ovr[2];
  bit            m_tmo;

  task automatic chk(string nm, int c, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, c, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_pend[0] = 0;
    m_pend[1] = 0;
    m_buf[0]  = '0;
    m_buf[1]  = '0;
    m_last    = 1;
    m_phase   = 0;
    m_waited  = 0;
    m_ovr[0]  = 0;
    m_ovr[1]  = 0;
    m_tmo     = 0;
  endfunction

  function automatic void m_step(
    bit rn, bit clr, bit le, bit re,
    logic [DW-1:0] ld, logic [DW-1:0] rd, bit dn);
    int            g = -1;
    bit            tevt = 0;
    bit            evt;
    bit            en[2];
    logic [DW-1:0] din[2];
    job_t          j;
    en[0]  = le;
    en[1]  = re;
    din[0] = ld;
    din[1] = rd;
    if (m_phase == 0) begin
      if (rn && (m_pend[0] || m_pend[1])) begin
        if (m_pend[0] && m_pend[1]) g = m_last ? 0 : 1;
        else g = m_pend[1] ? 1 : 0;
        j.cyc  = cyc + 1;
        j.chan = (g == 1);
        j.data = m_buf[g];
        jq.push_back(j);
        m_last  = (g == 1);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase  = 2;
      m_waited = 0;
    end else begin
      if (dn) begin
        m_phase = 0;
      end else begin
        m_waited++;
        if (m_waited == T) begin
          m_phase = 0;
          tevt    = 1;
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      evt = rn && en[i] && m_pend[i] && (g != i);
      if (!rn) m_pend[i] = 0;
      else if (en[i]) begin
        m_pend[i] = 1;
        m_buf[i]  = din[i];
      end else if (g == i) m_pend[i] = 0;
      m_ovr[i] = (clr ? 1'b0 : m_ovr[i]) | evt;
    end
    m_tmo = (clr ? 1'b0 : m_tmo) | tevt;
  endfunction

  task automatic tick(
    bit rst, bit rn, bit clr, bit le, bit re,
    logic [DW-1:0] ld, logic [DW-1:0] rd, bit dn);
    stat_t s;
    @(posedge clk);
    #1;
    cyc++;
    reset      = rst;
    run        = rn;
    clr_status = clr;
    l_data_en  = le;
    r_data_en  = re;
    l_data_in  = ld;
    r_data_in  = rd;
    eng_done   = dn;
    if (rst) begin
      m_reset();
      jq.delete();
    end
    s.cyc   = cyc;
    s.start = (m_phase == 1);
    s.busy  = (m_phase != 0);
    s.lo    = m_ovr[0];
    s.ro    = m_ovr[1];
    s.to    = m_tmo;
    sq.push_back(s);
    if (!rst) m_step(rn, clr, le, re, ld, rd, dn);
  endtask

  task automatic idle(int n, bit rn, bit dn);
    repeat (n) tick(0, rn, 0, 0, 0, '0, '0, dn);
  endtask

  task automatic send_l(logic [DW-1:0] d, bit dn);
    tick(0, 1, 0, 1, 0, d, '0, dn);
  endtask

  always @(negedge clk) begin : monitor
    stat_t e;
    job_t  j;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("busy", e.cyc, int'(busy), int'(e.busy));
      chk("l_overrun", e.cyc, int'(l_overrun), int'(e.lo));
      chk("r_overrun", e.cyc, int'(r_overrun), int'(e.ro));
      chk("timeout_err", e.cyc, int'(timeout_err), int'(e.to));
      chk("eng_start", e.cyc, int'(eng_start), int'(e.start));
      if (eng_start) begin
        if (jq.size() == 0) begin
          chk("job_present", e.cyc, 0, 1);
        end else begin
          j = jq.pop_front();
          chk("job_cycle", e.cyc, e.cyc, j.cyc);
          chk("eng_chan", e.cyc, int'(eng_chan), int'(j.chan));
          chk("eng_data", e.cyc, int'(eng_data), int'(j.data));
        end
      end
    end
  end

  initial begin
    m_reset();
    repeat (3) tick(1, 0, 0, 0, 0, '0, '0, 0);
    idle(6, 1, 0);

    // single left sample, done after a few wait cycles
    send_l(24'h123456, 0);
    idle(4, 1, 0);
    idle(1, 1, 1);
    idle(3, 1, 0);

    // simultaneous pairs alternate starting with left
    repeat (2) begin
      tick(0, 1, 0, 1, 1, 24'h000001, 24'h000002, 0);
      idle(3, 1, 0);
      idle(1, 1, 1);
      idle(3, 1, 0);
      idle(1, 1, 1);
      idle(2, 1, 0);
    end

    // overrun: B replaced by C while the engine is busy
    send_l(24'h0000aa, 0);
    idle(2, 1, 0);
    send_l(24'h0000bb, 0);
    idle(1, 1, 0);
    send_l(24'h0000cc, 0);
    idle(2, 1, 0);
    idle(1, 1, 1);
    idle(3, 1, 0);
    idle(1, 1, 1);
    idle(2, 1, 0);
    tick(0, 1, 1, 0, 0, '0, '0, 0);
    idle(2, 1, 0);

    // timeout with a right sample waiting behind it
    send_l(24'h00f00d, 0);
    idle(5, 1, 0);
    tick(0, 1, 0, 0, 1, '0, 24'hbeef01, 0);
    idle(20, 1, 0);
    idle(1, 1, 1);
    idle(3, 1, 0);
    tick(0, 1, 1, 0, 0, '0, '0, 0);

    // run dropped mid-job with right pending
    send_l(24'h0a0a0a, 0);
    idle(3, 1, 0);
    tick(0, 1, 0, 0, 1, '0, 24'h0b0b0b, 0);
    idle(2, 0, 0);
    idle(1, 0, 1);
    repeat (4) tick(0, 0, 0, 1, 1, 24'h1, 24'h2, 0);
    idle(4, 1, 0);
    send_l(24'h0c0c0c, 0);
    idle(3, 1, 0);
    idle(1, 1, 1);
    idle(2, 1, 0);

    // reset pulse in the middle of a job
    send_l(24'h0d0d0d, 0);
    idle(3, 1, 0);
    tick(1, 1, 0, 0, 0, '0, '0, 0);
    tick(1, 1, 0, 0, 0, '0, '0, 0);
    send_l(24'h0e0e0e, 0);
    idle(4, 1, 0);
    idle(1, 1, 1);
    idle(2, 1, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit rn;
      bit dn;
      rn = ($urandom_range(15) != 0);
      dn = ($urandom_range(99) < 20);
      tick(($urandom_range(599) == 0), rn,
           ($urandom_range(31) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           DW'($urandom), DW'($urandom), dn);
    end

    idle(T + 4, 1, 1);
    @(negedge clk);
    #1;
    chk("job_queue_empty", cyc, jq.size(), 0);
    chk("stat_queue_empty", cyc, sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Shares one time-multiplexed FIR MAC engine between the left and right interpolator sample streams. Each channel has a one-deep pending buffer. The block arbitrates round-robin, issues one job at a time to the engine, and waits for the engine's completion. It sits between the linear interpolator outputs and the FIR filter bank, and reports overrun and timeout status for the CPU status register.

Parameters:
DATA_WIDTH, 24, sample width of the channel inputs and engine data
TIMEOUT_CYCLES, 2047, maximum number of WAIT cycles before a job is abandoned
CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived)

Ports:
clk  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  enable, from audio_control[0]
clr_status  in  1  one-cycle strobe that clears the sticky status bits
l_data_en  in  1  left sample valid strobe
r_data_en  in  1  right sample valid strobe
l_data_in  in  DATA_WIDTH  left sample
r_data_in  in  DATA_WIDTH  right sample
eng_start  out  1  one-cycle job start pulse to the engine
eng_chan  out  1  channel of the current job: 0=left, 1=right
eng_data  out  DATA_WIDTH  sample of the current job
eng_done  in  1  engine completion strobe
busy  out  1  high while state is ISSUE or WAIT
l_overrun  out  1  sticky: a left sample was dropped
r_overrun  out  1  sticky: a right sample was dropped
timeout_err  out  1  sticky: the engine did not signal done in time

Behaviour:
- Reset (asynchronous): state=IDLE, both pending flags=0, last_served=R (so left wins first), timeout counter=0. All outputs are 0, including eng_data.
- Pending buffers, one per channel (flag plus data register):
  - x_data_en with run=1 latches x_data_in and sets x_pend.
  - If x_pend is already set and not being granted in that same cycle, the new sample overwrites the old one (newest wins) and x_overrun is set.
  - If grant and a new x_data_en occur in the same cycle, the granted job takes the old data, the new data is latched, and x_pend stays 1. This is not an overrun.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if run=1 and any pending flag is set, grant a channel.
    - If only one channel is pending, grant it.
    - If both are pending, grant the channel that is not last_served.
    - On grant: clear that channel's pending flag; register eng_chan and eng_data; update last_served; go to ISSUE.
  - ISSUE: eng_start=1 for exactly this cycle; go to WAIT; timeout counter cleared.
  - WAIT:
    - eng_done=1: go to IDLE.
    - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, set timeout_err and go to IDLE.
    - eng_done is ignored in IDLE and ISSUE.
- eng_chan and eng_data are held stable from ISSUE through the last WAIT cycle. After that they keep their values until the next grant.
- Latency: a strobe in cycle N gives pending=1 in N+1. With the FSM idle, eng_start is high in cycle N+2. The minimum back-to-back job spacing is 3 cycles when done returns in the first WAIT cycle.
- run=0:
  - Input strobes are ignored and both pending flags are cleared.
  - A job in WAIT still completes, either by done or by timeout; the FSM then stays in IDLE.
  - Sticky status bits are retained.
- clr_status clears all three sticky bits. If a set event and clr_status occur in the same cycle, the set wins.
- Reset asserted mid-job: immediate return to reset values, with no eng_start glitch.

Decomposition:
- Shared package audio_pkg holds:
  - the state encoding enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - the CHAN_L/CHAN_R constants;
  - the DATA_WIDTH default of 24 shared with the interpolator and FIR bank.
- One natural sub-module, chan_pending_buf. It is instantiated twice and contains the flag, the data register, the overwrite logic and the overrun detect, with inputs en, din, grant, run, clr and outputs pend, dout, ovr_evt.
- Arbiter and FSM stay in the top level.

Test Plan:
- Single left sample: l_data_en with 24'h123456 at cycle 10 -> eng_start at cycle 12 with eng_chan=0 and eng_data=24'h123456; busy high from 12 until done. Done at cycle 15 -> busy low at 16.
- Simultaneous L and R strobes after reset (L=24'h000001, R=24'h000002) -> left job first. Right job eng_start occurs 2 cycles after the left job's done, with eng_data=24'h000002. Next simultaneous pair -> left first again (alternation holds).
- Overrun: engine held busy while three left strobes (A, B, C) arrive -> l_overrun=1. The next left job issues C. r_overrun stays 0. clr_status -> l_overrun=0.
- Timeout: eng_done never asserted, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT cycles. FSM returns to IDLE and serves the next pending sample.
- run dropped during WAIT with R pending -> the current job completes on done and R pending is cleared. No further eng_start occurs until run=1 and a new strobe arrives.
- Reset pulse during WAIT -> all outputs are 0 asynchronously. After release, a fresh L strobe produces eng_start 2 cycles later.
